// File: rtl/muldiv_seq.sv
// Radix-2 sequential multiply/divide unit for the RV M-extension ops.
// One shift-add or restoring shift-subtract step per clock; signed ops run on magnitudes.
module muldiv_seq #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [2:0]      req_op,
  input  logic [XLEN-1:0] req_a,
  input  logic [XLEN-1:0] req_b,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [XLEN-1:0] rsp_r,
  input  logic            flush,
  output logic [1:0]      dbg_state
);

  localparam int CNTW = $clog2(XLEN) + 1;

  // Handshake: a request is taken on a clock edge where req_valid && req_ready,
  // a result is taken on an edge where rsp_valid && rsp_ready; flush overrides both.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t              state;
  logic [2:0]          op;
  logic                neg;
  logic [CNTW-1:0]     cnt;
  logic [2*XLEN-1:0]   prod;
  logic [XLEN:0]       rem;
  logic [XLEN-1:0]     opb;

  logic                a_sgn, b_sgn, a_neg, b_neg;
  logic [XLEN-1:0]     a_abs, b_abs;
  logic                is_div, is_rem, div_zero, ovf, special, neg_flag;
  logic [XLEN-1:0]     special_r;

  logic [XLEN:0]       mul_sum;
  logic [2*XLEN-1:0]   mul_next, prod_fix;
  logic [XLEN+1:0]     div_shift, div_diff;
  logic                borrow;
  logic [XLEN:0]       rem_next;
  logic [XLEN-1:0]     q_next, q_fix, r_fix, res;

  // Operand conditioning at the accept edge.
  always_comb begin
    a_sgn     = (req_op == 3'd1) || (req_op == 3'd2) || (req_op == 3'd4) || (req_op == 3'd6);
    b_sgn     = (req_op == 3'd1) || (req_op == 3'd4) || (req_op == 3'd6);
    a_neg     = a_sgn & req_a[XLEN-1];
    b_neg     = b_sgn & req_b[XLEN-1];
    a_abs     = a_neg ? -req_a : req_a;
    b_abs     = b_neg ? -req_b : req_b;
    is_div    = req_op[2];
    is_rem    = req_op[2] & req_op[1];
    div_zero  = is_div && (req_b == '0);
    ovf       = is_div && !req_op[0] && (req_a == {1'b1, {(XLEN-1){1'b0}}}) && (req_b == '1);
    special   = div_zero || ovf;
    special_r = '0;
    if (div_zero) special_r = is_rem ? req_a : '1;
    else          special_r = is_rem ? '0 : req_a;
    neg_flag = 1'b0;
    case (req_op)
      3'd1, 3'd4: neg_flag = a_neg ^ b_neg;
      3'd2, 3'd6: neg_flag = a_neg;
      default:    neg_flag = 1'b0;
    endcase
  end

  // One iteration step; the multiplier/dividend lives in the low half of prod.
  always_comb begin
    mul_sum   = {1'b0, prod[2*XLEN-1:XLEN]} + (prod[0] ? {1'b0, opb} : '0);
    mul_next  = {mul_sum, prod[XLEN-1:1]};
    div_shift = {rem, prod[XLEN-1]};
    div_diff  = div_shift - {2'b00, opb};
    borrow    = div_diff[XLEN+1];
    rem_next  = borrow ? div_shift[XLEN:0] : div_diff[XLEN:0];
    q_next    = {prod[XLEN-2:0], ~borrow};
    prod_fix  = neg ? -mul_next : mul_next;
    q_fix     = neg ? -q_next : q_next;
    r_fix     = neg ? -rem_next[XLEN-1:0] : rem_next[XLEN-1:0];
    res       = '0;
    case (op)
      3'd0:             res = prod_fix[XLEN-1:0];
      3'd1, 3'd2, 3'd3: res = prod_fix[2*XLEN-1:XLEN];
      3'd4, 3'd5:       res = q_fix;
      default:          res = r_fix;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      req_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_r     <= '0;
      cnt       <= '0;
      prod      <= '0;
      rem       <= '0;
      opb       <= '0;
      op        <= '0;
      neg       <= 1'b0;
    end else if (flush) begin
      state     <= IDLE;
      req_ready <= 1'b1;
      rsp_valid <= 1'b0;
      cnt       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid && req_ready) begin
            op        <= req_op;
            neg       <= neg_flag;
            req_ready <= 1'b0;
            if (special) begin
              rsp_r     <= special_r;
              rsp_valid <= 1'b1;
              state     <= DONE;
            end else begin
              prod  <= {{XLEN{1'b0}}, a_abs};
              opb   <= b_abs;
              rem   <= '0;
              cnt   <= CNTW'(XLEN);
              state <= CALC;
            end
          end
        end
        CALC: begin
          if (op[2]) begin
            rem  <= rem_next;
            prod <= {{XLEN{1'b0}}, q_next};
          end else begin
            prod <= mul_next;
          end
          cnt <= cnt - CNTW'(1);
          // Sign fix-up is folded into the final step so rsp_r is written once.
          if (cnt == CNTW'(1)) begin
            rsp_r     <= res;
            rsp_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            req_ready <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          state     <= IDLE;
          req_ready <= 1'b1;
          rsp_valid <= 1'b0;
        end
      endcase
    end
  end

  assign dbg_state = state;

endmodule
